// File: rtl/daq_pkg.sv
// Shared types and constants for the DAQ scan sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package daq_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DAC_WAIT = 2'd1,
    ST_SETTLE   = 2'd2,
    ST_ADC_WAIT = 2'd3
  } state_t;

  // Shared settle/watchdog counter width; SETTLE_CYCLES and
  // TIMEOUT_CYCLES must both fit in this many bits.
  localparam int WDOG_W = 16;

  // Channel index width, never narrower than one bit.
  function automatic int ch_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/daq_ch_pick.sv
// Next enabled channel finder: first set mask bit above i_cur, optionally wrapping to the lowest set bit.
// Latency: combinational.
// Backpressure: none.
// Ports: i_mask channel enables, i_cur current index, i_wrap allow wrap-around,
//        o_idx chosen channel, o_found a channel was chosen.
module daq_ch_pick
  import daq_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_mask,
  input  logic [CH_W-1:0]   i_cur,
  input  logic              i_wrap,
  output logic [CH_W-1:0]   o_idx,
  output logic              o_found
);

  logic [CH_W-1:0] w_above_idx;
  logic [CH_W-1:0] w_low_idx;
  logic            w_above_found;
  logic            w_low_found;

  // Scanning downward leaves the lowest qualifying index in each result.
  always_comb begin
    w_above_found = 1'b0;
    w_above_idx   = '0;
    w_low_found   = 1'b0;
    w_low_idx     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_mask[i]) begin
        w_low_found = 1'b1;
        w_low_idx   = CH_W'(i);
        if (CH_W'(i) > i_cur) begin
          w_above_found = 1'b1;
          w_above_idx   = CH_W'(i);
        end
      end
    end
  end

  assign o_found = w_above_found | (i_wrap & w_low_found);
  assign o_idx   = w_above_found ? w_above_idx : w_low_idx;

endmodule

// File: rtl/daq_sequencer.sv
// Multi-channel DAC-set / settle / ADC-capture scan sequencer with continuous mode, stop, abort and watchdog.
// Latency: every event (start, dac_done, adc_done, abort, timeout) shows on the outputs one cycle later.
// Backpressure: dac_en_o/adc_en_o are level requests held until the matching done or the watchdog expires.
// Ports: host side start/cont/stop/abort/ch_mask/dac_in -> busy/done/timeout_err;
//        converter side dac_en_o/data_to_dac_o/dac_done, adc_en_o/adc_done/adc_in;
//        results ch_o, sample_o/sample_ch_o/sample_valid_o.
module daq_sequencer
  import daq_pkg::*;
#(
  parameter  int DATA_W         = 12,
  parameter  int NUM_CH         = 4,
  parameter  int SETTLE_CYCLES  = 4,
  parameter  int TIMEOUT_CYCLES = 1024,
  localparam int CH_W           = ch_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     cont,
  input  logic                     stop,
  input  logic                     abort,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic [NUM_CH*DATA_W-1:0] dac_in,
  input  logic                     dac_done,
  input  logic                     adc_done,
  input  logic [DATA_W-1:0]        adc_in,
  output logic                     dac_en_o,
  output logic [DATA_W-1:0]        data_to_dac_o,
  output logic                     adc_en_o,
  output logic [CH_W-1:0]          ch_o,
  output logic [DATA_W-1:0]        sample_o,
  output logic [CH_W-1:0]          sample_ch_o,
  output logic                     sample_valid_o,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err
);

  localparam logic [WDOG_W-1:0] WD_LAST     = WDOG_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [WDOG_W-1:0] SETTLE_LAST = WDOG_W'(SETTLE_CYCLES - 1);
  localparam logic              WD_EN       = (TIMEOUT_CYCLES > 0);
  localparam logic [CH_W-1:0]   CH_TOP      = CH_W'(NUM_CH - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NUM_CH-1:0]   r_mask;
  logic                r_cont;
  logic                r_stop_pend;
  logic [WDOG_W-1:0]   r_cnt;
  logic [CH_W-1:0]     r_ch;
  logic [DATA_W-1:0]   r_dac_word;
  logic [DATA_W-1:0]   r_sample;
  logic [CH_W-1:0]     r_sample_ch;
  logic                r_sample_vld;
  logic                r_done;
  logic                r_terr;

  logic [NUM_CH-1:0]   w_pick_mask;
  logic [CH_W-1:0]     w_pick_cur;
  logic                w_pick_wrap;
  logic [CH_W-1:0]     w_pick_idx;
  logic                w_pick_found;
  logic [DATA_W-1:0]   w_dac_word;
  logic                w_wd_exp;
  logic                w_settle_end;
  logic                w_launch;
  logic                w_capture;
  logic                w_timeout;
  logic                w_finish;

  // One picker serves both cases: from IDLE, searching above the top index
  // with wrap enabled yields the lowest enabled channel of the new mask.
  assign w_pick_mask = (r_state == ST_IDLE) ? ch_mask : r_mask;
  assign w_pick_cur  = (r_state == ST_IDLE) ? CH_TOP  : r_ch;
  // A stop arriving on the very cycle of the last capture still prevents the wrap.
  assign w_pick_wrap = (r_state == ST_IDLE) | (r_cont & ~(r_stop_pend | stop));

  daq_ch_pick #(.NUM_CH(NUM_CH)) u_pick (
    .i_mask  (w_pick_mask),
    .i_cur   (w_pick_cur),
    .i_wrap  (w_pick_wrap),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  assign w_dac_word   = dac_in[int'(w_pick_idx)*DATA_W +: DATA_W];
  assign w_wd_exp     = WD_EN && (r_cnt == WD_LAST);
  assign w_settle_end = (r_cnt == SETTLE_LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and the events that drive the datapath.
  // abort is checked first; an awaited done beats a watchdog expiring on the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (|ch_mask) begin
            w_launch    = 1'b1;
            w_state_nxt = ST_DAC_WAIT;
          end else begin
            w_finish = 1'b1;
          end
        end
      end
      ST_DAC_WAIT: begin
        if (abort)         w_state_nxt = ST_IDLE;
        else if (dac_done) w_state_nxt = ST_SETTLE;
        else if (w_wd_exp) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (abort)             w_state_nxt = ST_IDLE;
        else if (w_settle_end) w_state_nxt = ST_ADC_WAIT;
      end
      ST_ADC_WAIT: begin
        if (abort) w_state_nxt = ST_IDLE;
        else if (adc_done) begin
          w_capture = 1'b1;
          if (w_pick_found) begin
            w_launch    = 1'b1;
            w_state_nxt = ST_DAC_WAIT;
          end else begin
            w_finish    = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end else if (w_wd_exp) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs; the two enables come from exclusive states.
  always_comb begin
    dac_en_o = (r_state == ST_DAC_WAIT);
    adc_en_o = (r_state == ST_ADC_WAIT);
    busy     = (r_state != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask       <= '0;
      r_cont       <= 1'b0;
      r_stop_pend  <= 1'b0;
      r_cnt        <= '0;
      r_ch         <= '0;
      r_dac_word   <= '0;
      r_sample     <= '0;
      r_sample_ch  <= '0;
      r_sample_vld <= 1'b0;
      r_done       <= 1'b0;
      r_terr       <= 1'b0;
    end else begin
      r_done       <= w_finish | w_timeout;
      r_sample_vld <= w_capture;
      if (w_capture) begin
        r_sample    <= adc_in;
        r_sample_ch <= r_ch;
      end
      if (w_launch) begin
        r_ch       <= w_pick_idx;
        r_dac_word <= w_dac_word;
      end
      if ((r_state == ST_IDLE) && start) begin
        r_terr <= 1'b0;
        if (|ch_mask) begin
          r_mask <= ch_mask;
          r_cont <= cont;
        end
      end
      if (w_timeout) r_terr <= 1'b1;
      // Counter restarts on every state entry; it times both SETTLE and the waits.
      if (w_state_nxt != r_state) r_cnt <= '0;
      else if (r_state != ST_IDLE) r_cnt <= r_cnt + 1'b1;
      if (w_state_nxt == ST_IDLE)             r_stop_pend <= 1'b0;
      else if (stop && (r_state != ST_IDLE)) r_stop_pend <= 1'b1;
    end
  end

  assign data_to_dac_o  = r_dac_word;
  assign ch_o           = r_ch;
  assign sample_o       = r_sample;
  assign sample_ch_o    = r_sample_ch;
  assign sample_valid_o = r_sample_vld;
  assign done           = r_done;
  assign timeout_err    = r_terr;

endmodule

// File: tb/tb_daq_sequencer.sv
// Self-checking bench for daq_sequencer: table of scans, hand-written corner sequences,
// and randomized scans checked against a channel-list model.
module tb_daq_sequencer;

  localparam int DW     = 12;
  localparam int NCH    = 4;
  localparam int SETTLE = 4;
  localparam int TMO    = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0, cont = 1'b0, stop = 1'b0, abort = 1'b0;
  logic [3:0]    ch_mask = '0;
  logic [47:0]   dac_in = '0;
  logic          dac_done = 1'b0, adc_done = 1'b0;
  logic [DW-1:0] adc_in = '0;
  logic          dac_en_o, adc_en_o, sample_valid_o, busy, done, timeout_err;
  logic [DW-1:0] data_to_dac_o, sample_o;
  logic [1:0]    ch_o, sample_ch_o;

  daq_sequencer #(.DATA_W(DW), .NUM_CH(NCH), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .cont(cont), .stop(stop), .abort(abort),
    .ch_mask(ch_mask), .dac_in(dac_in), .dac_done(dac_done), .adc_done(adc_done), .adc_in(adc_in),
    .dac_en_o(dac_en_o), .data_to_dac_o(data_to_dac_o), .adc_en_o(adc_en_o), .ch_o(ch_o),
    .sample_o(sample_o), .sample_ch_o(sample_ch_o), .sample_valid_o(sample_valid_o),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int dac_delay = 3, adc_delay = 2, seed = 0;
  bit dac_hold = 1'b0;

  int cap_ch_q[$], cap_val_q[$], cap_cyc_q[$], done_cyc_q[$];
  int dac_ch_q[$], dac_w_q[$], gap_q[$];
  int both_hi = 0, idle_run = 0;
  bit prev_dac = 1'b0, prev_adc = 1'b0;
  int dcnt = 0, acnt = 0;

  function automatic logic [DW-1:0] adc_val(input int ch);
    return DW'(seed + 100 + ch);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples 1 time unit after the active edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (sample_valid_o) begin
      cap_ch_q.push_back(int'(sample_ch_o));
      cap_val_q.push_back(int'(sample_o));
      cap_cyc_q.push_back(cyc);
    end
    if (done) done_cyc_q.push_back(cyc);
    if (dac_en_o && !prev_dac) begin
      dac_ch_q.push_back(int'(ch_o));
      dac_w_q.push_back(int'(data_to_dac_o));
    end
    if (adc_en_o && !prev_adc) gap_q.push_back(idle_run);
    if (dac_en_o || !busy) idle_run = 0;
    else if (!adc_en_o) idle_run++;
    if (dac_en_o && adc_en_o) both_hi++;
    prev_dac = dac_en_o;
    prev_adc = adc_en_o;
  end

  // Converter model: answers each request after a programmable number of cycles.
  always @(posedge clk) begin
    #2;
    if (dac_en_o && !dac_hold) begin
      dcnt++;
      dac_done = (dcnt == dac_delay);
    end else begin
      dcnt = 0;
      dac_done = 1'b0;
    end
    if (adc_en_o) begin
      acnt++;
      adc_done = (acnt == adc_delay);
      adc_in = adc_val(int'(ch_o));
    end else begin
      acnt = 0;
      adc_done = 1'b0;
    end
  end

  // Expected capture order: enabled channels ascending, one pass, or for continuous
  // mode every pass already begun when stop was raised after sa captures.
  function automatic void model(input logic [3:0] m, input logic c, input int sa,
                                output int n, output logic [63:0] seq);
    int bits[$];
    int passes;
    n = 0;
    seq = '0;
    for (int i = 0; i < NCH; i++) if (m[i]) bits.push_back(i);
    passes = (c && bits.size() > 0) ? sa / bits.size() + 1 : 1;
    for (int p = 0; p < passes; p++)
      foreach (bits[j]) begin
        seq[4*n +: 4] = 4'(bits[j]);
        n++;
      end
  endfunction

  task automatic run_scan(input string tag, input logic [3:0] m, input logic c, input int sa,
                          input int dd, input int ad, input logic [47:0] words,
                          input int exp_n, input logic [63:0] exp_seq);
    int b_cap, b_dac, b_gap, b_done, ch;
    bit stopped, ok;
    stopped = 1'b0;
    ok = 1'b0;
    b_cap = cap_ch_q.size(); b_dac = dac_ch_q.size();
    b_gap = gap_q.size();    b_done = done_cyc_q.size();
    dac_delay = dd; adc_delay = ad; dac_in = words; ch_mask = m; cont = c;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk({tag, "_terr_clear"}, timeout_err, 0);
    for (int k = 0; k < 3000; k++) begin
      if (done_cyc_q.size() > b_done && !busy) begin ok = 1'b1; break; end
      if (sa >= 0 && !stopped && (cap_ch_q.size() - b_cap) >= sa) begin
        stop = 1'b1;
        stopped = 1'b1;
      end else stop = 1'b0;
      @(negedge clk);
    end
    stop = 1'b0;
    chk({tag, "_finished"}, ok, 1);
    chk({tag, "_n_capture"}, cap_ch_q.size() - b_cap, exp_n);
    chk({tag, "_n_dac"}, dac_ch_q.size() - b_dac, exp_n);
    chk({tag, "_n_done"}, done_cyc_q.size() - b_done, 1);
    for (int i = 0; i < exp_n; i++) begin
      ch = int'(exp_seq[4*i +: 4]);
      if (b_cap + i < cap_ch_q.size()) begin
        chk({tag, "_cap_ch"}, cap_ch_q[b_cap+i], ch);
        chk({tag, "_cap_val"}, cap_val_q[b_cap+i], adc_val(ch));
      end
      if (b_dac + i < dac_ch_q.size()) begin
        chk({tag, "_dac_ch"}, dac_ch_q[b_dac+i], ch);
        chk({tag, "_dac_word"}, dac_w_q[b_dac+i], words[ch*DW +: DW]);
      end
      if (b_gap + i < gap_q.size()) chk({tag, "_settle"}, gap_q[b_gap+i], SETTLE);
    end
    if (exp_n > 0 && cap_cyc_q.size() > 0 && done_cyc_q.size() > b_done)
      chk({tag, "_done_cycle"}, done_cyc_q[b_done], cap_cyc_q[cap_cyc_q.size()-1]);
    chk({tag, "_terr_end"}, timeout_err, 0);
  endtask

  typedef struct {
    logic [3:0]  mask;
    logic        cont;
    int          stop_after;
    int          dd;
    int          ad;
    logic [47:0] words;
    int          exp_n;
    logic [63:0] exp_seq;
  } vec_t;

  vec_t vt[6];

  initial begin
    int b_cap, b_done, hi, n;
    bit found;
    logic [63:0] seq;
    logic [3:0]  rm;
    logic        rc;
    int          rsa;

    vt[0] = '{4'b1111, 1'b0, -1, 3, 2, 48'hFFF789456ABC, 4, 64'h3210};
    vt[1] = '{4'b1010, 1'b0, -1, 3, 4, 48'h123456789ABC, 2, 64'h31};
    vt[2] = '{4'b0101, 1'b1,  2, 3, 2, 48'hFFF789456ABC, 4, 64'h2020};
    vt[3] = '{4'b1000, 1'b0, -1, 1, 1, 48'hA5A5A5A5A5A5, 1, 64'h3};
    vt[4] = '{4'b0001, 1'b1,  1, 2, 5, 48'h0000000007E1, 2, 64'h00};
    vt[5] = '{4'b0110, 1'b1,  4, 4, 1, 48'h321654987CBA, 6, 64'h212121};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {dac_en_o, adc_en_o, busy, done, timeout_err, sample_valid_o,
                          ch_o, sample_ch_o, data_to_dac_o, sample_o}, 0);
    reset = 1'b0;
    @(negedge clk);

    seed = 0;
    foreach (vt[i])
      run_scan($sformatf("vec%0d", i), vt[i].mask, vt[i].cont, vt[i].stop_after,
               vt[i].dd, vt[i].ad, vt[i].words, vt[i].exp_n, vt[i].exp_seq);

    // Empty mask: immediate done pulse, no requests.
    b_cap = dac_ch_q.size();
    ch_mask = 4'b0000;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("empty_done", done, 1);
    chk("empty_busy", busy, 0);
    @(negedge clk);
    chk("empty_done_pulse", done, 0);
    chk("empty_no_dac", dac_ch_q.size() - b_cap, 0);

    // Watchdog: withheld dac_done.
    dac_hold = 1'b1;
    ch_mask = 4'b0001;
    cont = 1'b0;
    b_cap = cap_ch_q.size();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    hi = 0;
    for (int k = 0; k < 100; k++) begin
      if (dac_en_o) hi++;
      else if (hi > 0) break;
      @(negedge clk);
    end
    chk("tmo_dac_en_cycles", hi, TMO);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_done", done, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_no_sample", cap_ch_q.size() - b_cap, 0);
    dac_hold = 1'b0;
    @(negedge clk);
    run_scan("after_tmo", 4'b0011, 1'b0, -1, 3, 2, 48'h111222333444, 2, 64'h10);

    // Abort during ADC_WAIT on ch2, together with adc_done.
    seed = 5;
    b_cap = cap_ch_q.size();
    b_done = done_cyc_q.size();
    dac_delay = 2; adc_delay = 3; ch_mask = 4'b1111; cont = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (adc_en_o && ch_o == 2'd2 && adc_done) begin found = 1'b1; break; end
    end
    chk("abort_reached_ch2", found, 1);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    chk("abort_idle", {busy, dac_en_o, adc_en_o}, 0);
    repeat (3) @(negedge clk);
    chk("abort_captures", cap_ch_q.size() - b_cap, 2);
    chk("abort_no_done", done_cyc_q.size() - b_done, 0);
    chk("abort_terr", timeout_err, 0);

    // Asynchronous reset while settling.
    seed = 0;
    dac_delay = 3; ch_mask = 4'b1111;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (busy && !dac_en_o && !adc_en_o) begin found = 1'b1; break; end
    end
    chk("rst_reached_settle", found, 1);
    #2 reset = 1'b1;
    #1 chk("rst_mid_settle_outputs", {dac_en_o, adc_en_o, busy, done, timeout_err, sample_valid_o,
                                      ch_o, sample_ch_o, data_to_dac_o, sample_o}, 0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    run_scan("after_rst", 4'b1111, 1'b0, -1, 3, 2, 48'hFFF789456ABC, 4, 64'h3210);

    // Randomized scans against the model.
    for (int it = 0; it < 12; it++) begin
      rm = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      rsa = rc ? $urandom_range(1, 4) : -1;
      seed = $urandom_range(0, 4095);
      model(rm, rc, rsa, n, seq);
      run_scan($sformatf("rnd%0d", it), rm, rc, rsa, $urandom_range(1, 6), $urandom_range(1, 6),
               {16'($urandom), $urandom}, n, seq);
    end

    chk("enables_exclusive", both_hi, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, %0d checks", n_checks);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/daq_sequencer.md
Name: daq_sequencer

Overview:
Parametrised multi-channel successor to the single-shot DAQ controller. On start it scans the enabled channels in ascending index order. For each channel it loads that channel's DAC word, waits for the DAC handshake, holds a settle delay, runs an ADC conversion and captures the result. It adds a channel mask, continuous-scan mode, a graceful stop, an abort, and a per-handshake timeout watchdog, and sits between the host register block and the DAC/ADC interface drivers.

Parameters:
DATA_W, 12, DAC/ADC sample width in bits
NUM_CH, 4, number of channels (2..16)
SETTLE_CYCLES, 4, idle cycles between dac_done and adc_en_o (must be >= 1)
TIMEOUT_CYCLES, 1024, max cycles waiting for dac_done/adc_done; 0 disables the watchdog

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  begin scan; sampled only in IDLE
cont  in  1  continuous mode; latched at start
stop  in  1  finish the current scan, then halt (continuous mode)
abort  in  1  immediate return to IDLE
ch_mask  in  NUM_CH  enabled channels; latched at start
dac_in  in  NUM_CH*DATA_W  per-channel DAC words, ch0 in LSBs; sampled when the channel is entered
dac_done  in  1  DAC write complete
adc_done  in  1  ADC conversion complete
adc_in  in  DATA_W  ADC result; valid when adc_done=1
dac_en_o  out  1  DAC request, level, held until dac_done
data_to_dac_o  out  DATA_W  current DAC word
adc_en_o  out  1  ADC request, level, held until adc_done
ch_o  out  clog2(NUM_CH)  active channel index
sample_o  out  DATA_W  last captured ADC word
sample_ch_o  out  clog2(NUM_CH)  channel of sample_o
sample_valid_o  out  1  one-cycle pulse per capture
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse at end of scan, timeout, or empty mask
timeout_err  out  1  sticky; cleared on the next accepted start

Behaviour:
- Reset: all outputs 0; FSM in IDLE; latched mask and cont cleared.
- States: IDLE, DAC_WAIT, SETTLE, ADC_WAIT.
- IDLE, start=1, ch_mask!=0: latch mask and cont, clear timeout_err.
  - Next cycle: DAC_WAIT with ch_o = lowest set bit, data_to_dac_o = that slice of dac_in, dac_en_o=1, busy=1.
- IDLE, start=1, ch_mask==0: done pulses next cycle; no enables asserted.
- DAC_WAIT, dac_done=1: next cycle dac_en_o=0, enter SETTLE. SETTLE lasts exactly SETTLE_CYCLES cycles with both enables low.
- After SETTLE: enter ADC_WAIT with adc_en_o=1.
- ADC_WAIT, adc_done=1: next cycle:
  - adc_en_o=0;
  - sample_o=adc_in, sample_ch_o=ch_o, sample_valid_o=1;
  - in the same cycle, either dac_en_o=1 for the next channel, or done=1.
- Next channel: next set mask bit above ch_o.
  - If none remain and cont=1 and no stop is pending: wrap to the lowest set bit.
  - Otherwise: done pulse, IDLE.
- stop: sets a pending flag at any time while busy; takes effect only at scan end. Cleared on entry to IDLE.
- Watchdog: counter zeroed on entry to DAC_WAIT/ADC_WAIT. Reaching TIMEOUT_CYCLES without the awaited done triggers:
  - next cycle: enables low, timeout_err=1, done=1, IDLE;
  - no sample_valid_o.
- A done input arriving on the same cycle the watchdog expires wins; no timeout.
- abort (any non-IDLE state, highest priority over all other events): next cycle enables low, IDLE. No done, no sample_valid_o, timeout_err unchanged.
- dac_done/adc_done outside their wait states are ignored. start while busy is ignored.
- dac_en_o and adc_en_o are never high together.
- Asynchronous reset mid-scan: immediate IDLE, all outputs 0.

Decomposition:
- daq_pkg: state enum, CH_W = clog2(NUM_CH) helper function, watchdog width constant.
- One sub-module, daq_ch_pick: combinational next-set-bit finder (mask, current index, wrap enable -> next index, found flag).

Test Plan:
- NUM_CH=4, mask=4'b1111, dac_in={FFF,789,456,ABC} (ch3..ch0), dac_done 3 cycles after each dac_en_o, adc_in=100+ch → four sample_valid_o pulses: ch0..3 with 100..103. data_to_dac_o=ABC,456,789,FFF in order. Exactly 4 cycles between dac_done and adc_en_o. done one cycle after the last capture.
- mask=4'b1010 → only ch1 then ch3 converted. mask=0 → done one cycle after start, enables never high.
- cont=1, mask=4'b0101, stop pulsed during the second pass on ch0 → sequence ch0,ch2,ch0,ch2, then done; no third pass.
- TIMEOUT_CYCLES=16, dac_done withheld → dac_en_o drops on cycle 17 with timeout_err=1 and done=1. Next start clears timeout_err.
- abort asserted in ADC_WAIT on ch2, same cycle as adc_done → IDLE, no sample_valid_o, no done.
- reset asserted mid-SETTLE → all outputs 0 immediately. A fresh start then runs a normal scan from ch0.
